// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep reader.
package tt_sweep_pkg;

  localparam int unsigned TT_ROWS = 8;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned CNT_W   = 8;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

endpackage

// File: rtl/tt_sweep_reader_if.sv
// Control and DUT-side signals of the sweep reader; master is the bench/host side.
interface tt_sweep_reader_if;
  import tt_sweep_pkg::*;

  logic  start;
  logic  abort;
  logic  dut_out;
  row_t  dut_in;
  logic  busy;
  logic  done;
  code_t code;
  logic  match;

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, code, match
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, code, match
  );

endinterface

// File: rtl/tt_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/tt_sweep_reader.sv
// Drives all eight rows of a 3-input gate, samples its output and assembles the truth-table code.
// Define TT_SWEEP_SYNC_EN to pass dut_out through a 2-flop synchroniser before capture.
module tt_sweep_reader
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter code_t       EXPECTED      = 8'h9B
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sweep_reader_if.slave   bus
);

  localparam row_t LAST_ROW = ROW_W'(TT_ROWS - 1);
  localparam cnt_t SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  if (SETTLE_CYCLES > 255) begin : g_range_chk
    $error("tt_sweep_reader: SETTLE_CYCLES must be 0..255");
  end

  logic sample;

`ifdef TT_SWEEP_SYNC_EN
  // The synchroniser eats two cycles of each row's settle window.
  if (SETTLE_CYCLES < 2) begin : g_sync_chk
    $error("tt_sweep_reader: SETTLE_CYCLES must be >= 2 with TT_SWEEP_SYNC_EN");
  end

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_out),
    .q     (sample)
  );
`else
  assign sample = bus.dut_out;
`endif

  state_t state_q, state_d;
  row_t   row_q,   row_d;
  cnt_t   cnt_q,   cnt_d;
  code_t  code_q,  code_d;
  logic   match_q, match_d;
  logic   busy_q,  busy_d;
  logic   done_q,  done_d;

  // Row r lands at code[7-r] so row 000 is the MSB.
  row_t bit_idx;
  assign bit_idx = ROW_W'(LAST_ROW - row_q);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          row_d   = '0;
          cnt_d   = SETTLE_LOAD;
          code_d  = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end else begin
          code_d[bit_idx] = sample;
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Final bit is folded in on the same edge it is captured.
            match_d = ({code_q[CODE_W-1:1], sample} == EXPECTED);
          end else begin
            row_d = ROW_W'(row_q + ROW_W'(1));
            cnt_d = SETTLE_LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Row register is zero outside a sweep, so it drives the DUT inputs directly.
  assign bus.dut_in = row_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.code   = code_q;
  assign bus.match  = match_q;

endmodule
